// File: rtl/mux_result_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : mux_result_fifo_if
// Description : Handshake bundle between the mux stage, the result FIFO and
//               the downstream consumer. The FIFO side uses the slave
//               modport; the producer/consumer side uses the master modport.
// Revision    : 1.0 - initial release
// ============================================================================
interface mux_result_fifo_if #(
  parameter int WIDTH = 32
) ();

  // Write side: mux result and its valid, no backpressure to the mux.
  logic             in_val;
  logic [WIDTH-1:0] In;

  // Read side: show-ahead head entry with a valid/ready handshake.
  logic             out_val;
  logic             out_rdy;
  logic [WIDTH-1:0] Out;

  // FIFO side.
  modport slave (
    input  in_val,
    input  In,
    input  out_rdy,
    output out_val,
    output Out
  );

  // Mux / consumer side.
  modport master (
    output in_val,
    output In,
    output out_rdy,
    input  out_val,
    input  Out
  );

endinterface : mux_result_fifo_if
`default_nettype wire

// File: rtl/mux_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mux_result_fifo
// Description : Show-ahead capture FIFO behind the registered 2:1 mux stage.
//               Every in_val beat is taken when there is room (or a pop frees
//               a slot in the same cycle); beats arriving into a full FIFO
//               with no pop are dropped and recorded in a sticky overflow
//               flag plus a saturating 8-bit drop counter.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_result_fifo #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 8,
  parameter int AFULL_LVL = 6
) (
  input  wire logic                   Clk,
  input  wire logic                   Reset_n,
  mux_result_fifo_if.slave            bus,
  input  wire logic                   clr_ovf,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        overflow,
  output logic [7:0]                  drop_cnt
);

  // Pointer width addresses DEPTH entries; the count needs one more bit to
  // represent DEPTH itself. DEPTH is a power of two so pointers wrap for free.
  localparam int               C_AW       = $clog2(DEPTH);
  localparam int               C_CW       = C_AW + 1;
  localparam logic [C_CW-1:0]  C_DEPTH    = C_CW'(DEPTH);
  localparam logic [C_CW-1:0]  C_AFULL    = C_CW'(AFULL_LVL);
  localparam logic [7:0]       C_DROP_MAX = 8'hFF;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [C_AW-1:0]  r_wr_ptr;
  logic [C_AW-1:0]  r_rd_ptr;
  logic [C_CW-1:0]  r_count;
  logic             r_overflow;
  logic [7:0]       r_drop_cnt;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;

  // Flags are decoded from the registered count so they line up with it.
  assign w_full  = (r_count == C_DEPTH);
  assign w_empty = (r_count == '0);

  // A pop only happens with data present, so out_rdy is ignored when empty.
  assign w_pop  = !w_empty && bus.out_rdy;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push = bus.in_val && (!w_full || w_pop);
  assign w_drop = bus.in_val && w_full && !w_pop;

  // Storage: cleared on reset so Out reads 0 afterwards; written only on push
  // so In is never sampled while in_val is low.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= bus.In;
    end
  end

  // Write pointer advances on every accepted beat.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_wr_ptr <= '0;
    end else if (w_push) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
    end
  end

  // Read pointer advances on every completed handshake.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rd_ptr <= '0;
    end else if (w_pop) begin
      r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Occupancy: simultaneous push and pop leave the count unchanged.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Loss tracking: a drop takes priority over a clear in the same cycle, so
  // the beat lost that cycle is always visible afterwards.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (clr_ovf) begin
        r_drop_cnt <= 8'd1;
      end else if (r_drop_cnt != C_DROP_MAX) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end else if (clr_ovf) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  // Show-ahead read: head entry is presented without waiting for a pop.
  assign bus.Out     = r_mem[r_rd_ptr];
  assign bus.out_val = !w_empty;

  assign count       = r_count;
  assign full        = w_full;
  assign empty       = w_empty;
  assign almost_full = (r_count >= C_AFULL);
  assign overflow    = r_overflow;
  assign drop_cnt    = r_drop_cnt;

endmodule : mux_result_fifo
`default_nettype wire

// File: tb/tb_mux_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_result_fifo
// Description : Directed, table-driven bench for mux_result_fifo with
//               hand-written sequences for wrap, streaming, drop saturation
//               and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_result_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;

  logic        Clk;
  logic        Reset_n;
  logic        clr_ovf;
  logic [3:0]  count;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int n_vec;
  int n_bad;

  mux_result_fifo_if #(.WIDTH(WIDTH)) bus ();

  mux_result_fifo #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .AFULL_LVL(6)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .bus        (bus),
    .clr_ovf    (clr_ovf),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .almost_full(almost_full),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

  // 100 MHz clock, rising edges at 5, 15, 25 ...
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        iv;
    logic [31:0] din;
    logic        rdy;
    logic        clr;
    logic        ev;
    logic [31:0] eo;
    int          ec;
    logic        eovf;
    int          ed;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic iv, input logic [31:0] din, input logic rdy,
                     input logic clr, input logic ev, input logic [31:0] eo,
                     input int ec, input logic eovf, input int ed);
    vec_t v;
    v.iv = iv; v.din = din; v.rdy = rdy; v.clr = clr;
    v.ev = ev; v.eo = eo; v.ec = ec; v.eovf = eovf; v.ed = ed;
    vt.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Full status check; flags are derived from the expected count.
  task automatic chk_status(input string name, input logic ev, input int ec,
                            input logic eovf, input int ed);
    chk({name, ".out_val"},     {31'd0, bus.out_val}, {31'd0, ev});
    chk({name, ".count"},       {28'd0, count},       ec);
    chk({name, ".full"},        {31'd0, full},        {31'd0, ec == DEPTH});
    chk({name, ".empty"},       {31'd0, empty},       {31'd0, ec == 0});
    chk({name, ".almost_full"}, {31'd0, almost_full}, {31'd0, ec >= 6});
    chk({name, ".overflow"},    {31'd0, overflow},    {31'd0, eovf});
    chk({name, ".drop_cnt"},    {24'd0, drop_cnt},    ed);
  endtask

  // Apply inputs, let one rising edge pass, then settle away from the edge.
  task automatic step(input logic iv, input logic [31:0] din, input logic rdy,
                      input logic clr);
    bus.in_val  = iv;
    bus.In      = iv ? din : 32'hxxxx_xxxx;
    bus.out_rdy = rdy;
    clr_ovf     = clr;
    @(posedge Clk);
    #2;
  endtask

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  logic [31:0] drain_exp [7];

  initial begin
    n_vec = 0;
    n_bad = 0;
    drain_exp = '{32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h1234_5678};

    // ---------------- vector table ----------------
    add(0, 32'h0,         0, 0, 0, 32'h0,         0, 0, 0);  // idle after reset
    add(1, 32'hA5A5_0001, 0, 0, 1, 32'hA5A5_0001, 1, 0, 0);  // single push
    add(0, 32'h0,         1, 0, 0, 32'h0,         0, 0, 0);  // single pop
    for (int i = 0; i < 8; i++)                              // fill 0..7, head stays 0
      add(1, i, 0, 0, 1, 32'h0, i + 1, 0, 0);
    add(1, 32'h1234_5678, 1, 0, 1, 32'h1,         8, 0, 0);  // full, push+pop
    add(1, 32'hDEAD_BEEF, 0, 0, 1, 32'h1,         8, 1, 1);  // full, drop
    for (int k = 0; k < 7; k++)                              // drain
      add(0, 32'h0, 1, 0, 1, drain_exp[k], 7 - k, 1, 1);
    add(0, 32'h0,         1, 0, 0, 32'h0,         0, 1, 1);  // last pop
    add(0, 32'h0,         1, 1, 0, 32'h0,         0, 0, 0);  // clear, rdy ignored
    add(1, 32'h0000_0055, 1, 0, 1, 32'h0000_0055, 1, 0, 0);  // push while empty
    add(0, 32'h0,         1, 0, 0, 32'h0,         0, 0, 0);

    // ---------------- reset ----------------
    Reset_n     = 1'b0;
    bus.in_val  = 1'b0;
    bus.In      = '0;
    bus.out_rdy = 1'b0;
    clr_ovf     = 1'b0;
    repeat (2) @(posedge Clk);
    #2;
    Reset_n = 1'b1;
    chk_status("reset", 0, 0, 0, 0);
    chk("reset.Out", bus.Out, 32'h0);

    // ---------------- table ----------------
    foreach (vt[n]) begin
      step(vt[n].iv, vt[n].din, vt[n].rdy, vt[n].clr);
      chk_status($sformatf("vec%0d", n), vt[n].ev, vt[n].ec, vt[n].eovf, vt[n].ed);
      if (vt[n].ev)
        chk($sformatf("vec%0d.Out", n), bus.Out, vt[n].eo);
    end

    // ---------------- wrap: three fill/drain rounds ----------------
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) begin
        step(1, 32'h100 * (r + 1) + i, 0, 0);
        chk($sformatf("wrap%0d.fill%0d.count", r, i), {28'd0, count}, i + 1);
      end
      chk($sformatf("wrap%0d.full", r), {31'd0, full}, 32'd1);
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("wrap%0d.head%0d", r, i), bus.Out, 32'h100 * (r + 1) + i);
        step(0, 32'h0, 1, 0);
      end
      chk($sformatf("wrap%0d.empty", r), {31'd0, empty}, 32'd1);
    end

    // ---------------- sustained push+pop with out_rdy held high ----------------
    step(1, 32'hF000, 1, 0);
    chk_status("stream.first", 1, 1, 0, 0);
    chk("stream.first.Out", bus.Out, 32'hF000);
    for (int i = 1; i < 10; i++) begin
      step(1, 32'hF000 + i, 1, 0);
      chk($sformatf("stream%0d.count", i), {28'd0, count}, 32'd1);
      chk($sformatf("stream%0d.Out", i), bus.Out, 32'hF000 + i);
    end
    step(0, 32'h0, 1, 0);
    chk_status("stream.end", 0, 0, 0, 0);

    // ---------------- drop saturation and clear ----------------
    for (int i = 0; i < 8; i++) step(1, 32'hB000 + i, 0, 0);
    for (int i = 0; i < 300; i++) step(1, 32'hEEEE_0000 + i, 0, 0);
    chk_status("sat", 1, 8, 1, 255);
    chk("sat.Out", bus.Out, 32'hB000);
    step(0, 32'h0, 0, 1);
    chk_status("clr", 1, 8, 0, 0);
    step(1, 32'hEEEE_FFFF, 0, 1);
    chk_status("clr_drop", 1, 8, 1, 1);

    // ---------------- async reset mid-cycle with count=5 ----------------
    for (int i = 0; i < 3; i++) step(0, 32'h0, 1, 0);
    chk_status("pre_rst", 1, 5, 1, 1);
    chk("pre_rst.Out", bus.Out, 32'hB003);
    bus.out_rdy = 1'b0;
    #2;                       // 4 ns after the edge, well before the next one
    Reset_n = 1'b0;
    #1;
    chk_status("async_rst", 0, 0, 0, 0);
    chk("async_rst.Out", bus.Out, 32'h0);
    #2;
    Reset_n = 1'b1;
    step(1, 32'hC0DE_0001, 0, 0);
    chk_status("post_rst.push1", 1, 1, 0, 0);
    chk("post_rst.Out1", bus.Out, 32'hC0DE_0001);
    step(1, 32'hC0DE_0002, 1, 0);
    chk("post_rst.Out2", bus.Out, 32'hC0DE_0002);
    chk("post_rst.count", {28'd0, count}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_mux_result_fifo
`default_nettype wire

// File: doc/mux_result_fifo.md
Name: mux_result_fifo

Overview:
- Downstream capture buffer for the registered 2:1 mux stage.
- Accepts each mux result qualified by the mux output valid (no backpressure to the mux) into a show-ahead FIFO.
- Presents results to the consumer over a valid/ready handshake.
- Flags results lost to overflow with a sticky flag and a drop counter, so the bench and system can detect lost data.

Parameters:
- WIDTH, 32, data width; matches the mux data path.
- DEPTH, 8, entry count; power of 2, at least 2.
- AFULL_LVL, 6, almost_full asserts when count >= AFULL_LVL; must be 1..DEPTH.

Ports:
- Clk  input  1  rising-edge clock, sole clock domain.
- Reset_n  input  1  asynchronous active-low reset.
- in_val  input  1  mux result valid; connect to the mux out_val.
- In  input  WIDTH  mux result data; connect to the mux Out.
- out_rdy  input  1  consumer ready.
- clr_ovf  input  1  synchronous clear of overflow and drop_cnt.
- out_val  output  1  head entry valid (= !empty).
- Out  output  WIDTH  head entry data (show-ahead).
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AFULL_LVL.
- overflow  output  1  sticky; set when an in_val beat is dropped.
- drop_cnt  output  8  number of dropped beats; saturates at 255.

Behaviour:
- Reset (Reset_n low, async assert, sync-released use):
  - pointers, count, overflow and drop_cnt go to 0.
  - out_val=0, empty=1, full=0, almost_full=0.
  - Out=0 (the storage array is cleared).
  - Any entry in flight is discarded.
- Push: in_val=1 and (!full or pop in the same cycle). The entry is written at wr_ptr and wr_ptr advances, wrapping from DEPTH-1 to 0.
- Pop: out_val=1 and out_rdy=1. rd_ptr advances with the same wrap rule.
- Out is driven combinationally from mem[rd_ptr]. The value is only meaningful while out_val=1.
- Latency: a beat pushed on edge N gives out_val=1 and Out=data after edge N when the FIFO was empty. There is no fall-through in the same cycle.
- Occupancy updates per edge:
  - push only: count+1
  - pop only: count-1
  - push and pop: count unchanged
  - neither: count unchanged
- Full with push and pop in the same cycle: the push is accepted and count stays at DEPTH. No drop occurs.
- Full with push and no pop: the beat is dropped and storage is unchanged. overflow is set to 1 on that edge, and drop_cnt increments unless it is already 255.
- Empty: out_rdy is ignored, with no pointer movement or underflow. A push while empty is a push only.
- clr_ovf=1: overflow goes to 0 and drop_cnt goes to 0 on the next edge. If a drop occurs in the same cycle, the drop wins: overflow=1 and drop_cnt=1.
- full, empty and almost_full are decoded from the registered count. They are valid in the same cycle as count.
- out_rdy may be held high continuously. The FIFO sustains 1 push and 1 pop per cycle indefinitely.
- In is sampled only when in_val=1. X on In while in_val=0 must not propagate.

Test Plan:
- Reset, then drive in_val with In=32'hA5A5_0001: one cycle later out_val=1, Out=32'hA5A5_0001, count=1. Assert out_rdy for 1 cycle: empty=1, count=0.
- Push 8 beats 32'h0..32'h7 with out_rdy=0: count reaches 8, full=1. almost_full first rises when count=6. Drain with out_rdy=1: Out is 0..7 in order, and wrap is exercised by 3 further fill/drain cycles.
- With the FIFO full, push 32'hDEAD_BEEF with out_rdy=0: no storage change, overflow=1, drop_cnt=1. The drained sequence excludes 32'hDEAD_BEEF.
- With the FIFO full, push 32'h1234_5678 with out_rdy=1 in the same cycle: count stays 8, overflow stays 0. The last beat drained is 32'h1234_5678.
- Drop 300 beats into a full FIFO: drop_cnt saturates at 255. clr_ovf for 1 cycle gives 0/0. clr_ovf coinciding with a drop gives overflow=1, drop_cnt=1.
- Deassert Reset_n mid-cycle with count=5: out_val, count and overflow clear immediately, without waiting for Clk. After release, the first new push is the first beat out.
